// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one DRAM controller port between icache and dcache
module mem_arbiter #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [2:0]            i_rd_ctrl,
    output logic                  i_gnt,
    output logic                  i_ack,
    output logic [DATA_WIDTH-1:0] i_dout,
    input  logic                  d_req,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_din,
    input  logic [2:0]            d_rd_ctrl,
    input  logic [2:0]            d_wr_ctrl,
    output logic                  d_gnt,
    output logic                  d_ack,
    output logic [DATA_WIDTH-1:0] d_dout,
    input  logic [1:0]            dram_state,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic [DATA_WIDTH-1:0] dram_din,
    input  logic [DATA_WIDTH-1:0] dram_dout,
    output logic [2:0]            dram_rd_ctrl,
    output logic [2:0]            dram_wr_ctrl,
    output logic [3:0]            beat_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t state;
    logic   last_owner;
    logic   beat_done;

    assign i_gnt     = (state == GRANT_I);
    assign d_gnt     = (state == GRANT_D);
    assign beat_done = (dram_state == 2'b00) && ((dram_rd_ctrl != 3'b000) || (dram_wr_ctrl != 3'b000));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= OWNER_I;
            beat_cnt   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= 4'd0;
                    // On a tie the requester that did not own the port last time wins
                    if (i_req && d_req) begin
                        if (last_owner == OWNER_I) begin
                            state      <= GRANT_D;
                            last_owner <= OWNER_D;
                        end else begin
                            state      <= GRANT_I;
                            last_owner <= OWNER_I;
                        end
                    end else if (d_req) begin
                        state      <= GRANT_D;
                        last_owner <= OWNER_D;
                    end else if (i_req) begin
                        state      <= GRANT_I;
                        last_owner <= OWNER_I;
                    end
                end
                GRANT_I: begin
                    if (!i_req) begin
                        state    <= IDLE;
                        beat_cnt <= 4'd0;
                    end else if (i_ack && (beat_cnt != 4'd15)) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                GRANT_D: begin
                    if (!d_req) begin
                        state    <= IDLE;
                        beat_cnt <= 4'd0;
                    end else if (d_ack && (beat_cnt != 4'd15)) begin
                        beat_cnt <= beat_cnt + 4'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= 4'd0;
                end
            endcase
        end
    end

    // Owner's request is forwarded combinationally so DRAM sees it the cycle gnt rises
    always_comb begin
        dram_addr    = '0;
        dram_din     = '0;
        dram_rd_ctrl = 3'b000;
        dram_wr_ctrl = 3'b000;
        i_dout       = '0;
        d_dout       = '0;
        i_ack        = 1'b0;
        d_ack        = 1'b0;
        case (state)
            GRANT_I: begin
                dram_addr    = i_addr;
                dram_rd_ctrl = i_rd_ctrl;
                i_dout       = dram_dout;
                i_ack        = beat_done;
            end
            GRANT_D: begin
                dram_addr    = d_addr;
                dram_din     = d_din;
                dram_rd_ctrl = d_rd_ctrl;
                dram_wr_ctrl = d_wr_ctrl;
                d_dout       = dram_dout;
                d_ack        = beat_done;
            end
            default: begin
            end
        endcase
    end

endmodule
